frame_config_loader: RTL



---
 rtl/frame_cfg_pkg.sv | 21 ++
 rtl/frame_strobe_decoder.sv | 45 ++++
 rtl/frame_config_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared types and constants for the column configuration loader
package frame_cfg_pkg;

    localparam int          FRAME_BITS_DEFAULT = 32;
    localparam logic [31:0] SYNC_WORD_DEFAULT  = 32'hFAB0_FAB1;

    // Header word layout
    localparam int HDR_END_BIT   = 31;
    localparam int HDR_COL_MSB   = 15;
    localparam int HDR_COL_LSB   = 8;
    localparam int HDR_FRAME_MSB = 7;
    localparam int HDR_FRAME_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - registered col/frame to one-hot FrameStrobe decoder
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   en          : decode this cycle; output is all-zero on the next edge otherwise
//   col, frame  : target column and frame within the column
//   strobe      : registered one-hot, bit col*MaxFramesPerCol+frame
module frame_strobe_decoder #(
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 4
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  en,
    input  logic [7:0]                            col,
    input  logic [7:0]                            frame,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

    logic [NumColumns*MaxFramesPerCol-1:0] hit;

    // Explicit compare per line: an out-of-range col/frame yields no hit at all,
    // so the output can never alias onto another column's latches.
    always_comb begin
        hit = '0;
        if (en) begin
            for (int c = 0; c < NumColumns; c++) begin
                for (int f = 0; f < MaxFramesPerCol; f++) begin
                    if ((col == 8'(c)) && (frame == 8'(f))) begin
                        hit[c*MaxFramesPerCol+f] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            strobe <= '0;
        end else begin
            strobe <= hit;
        end
    end

endmodule

// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - bitstream word parser driving FrameData/FrameStrobe for fabric columns
//
// Ports:
//   CLK, resetn     : configuration clock, asynchronous active-low reset
//   in_data         : bitstream word
//   in_valid        : in_data valid
//   in_ready        : loader accepts in_data this cycle
//   FrameData       : frame contents broadcast to tile config latches
//   FrameStrobe     : one-hot latch enable, index col*MaxFramesPerCol+frame
//   cfg_active      : a configuration session is open
//   cfg_err         : sticky, an out-of-range header was seen
//   frames_written  : saturating count of strobes issued
module frame_config_loader
    import frame_cfg_pkg::*;
#(
    parameter int          FrameBitsPerRow = FRAME_BITS_DEFAULT,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumColumns      = 4,
    parameter logic [31:0] SyncWord        = SYNC_WORD_DEFAULT
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic [FrameBitsPerRow-1:0]            in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [FrameBitsPerRow-1:0]            FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  cfg_active,
    output logic                                  cfg_err,
    output logic [15:0]                           frames_written
);

    localparam logic [7:0] NUM_COLS_B   = 8'(NumColumns);
    localparam logic [7:0] NUM_FRAMES_B = 8'(MaxFramesPerCol);

    cfg_state_t state_q, state_d;

    logic [7:0] col_q;
    logic [7:0] frame_q;
    logic       xfer;
    logic       in_range;
    logic       ld_hdr;
    logic       ld_data;
    logic       set_err;
    logic       set_active;
    logic       clr_active;
    logic       strobe_en;

    // Held low through reset so nothing upstream believes a word was taken.
    assign in_ready = resetn && (state_q != STROBE);
    assign xfer     = in_valid && in_ready;
    assign in_range = (col_q < NUM_COLS_B) && (frame_q < NUM_FRAMES_B);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_hdr     = 1'b0;
        ld_data    = 1'b0;
        set_err    = 1'b0;
        set_active = 1'b0;
        clr_active = 1'b0;
        strobe_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && (in_data == SyncWord)) begin
                    state_d    = HDR;
                    set_active = 1'b1;
                end
            end
            HDR: begin
                // A SyncWord here has bit31 set, so it closes the session too.
                if (xfer) begin
                    if (in_data[HDR_END_BIT]) begin
                        state_d    = IDLE;
                        clr_active = 1'b1;
                    end else begin
                        state_d = DATA;
                        ld_hdr  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (in_range) begin
                        state_d = STROBE;
                        ld_data = 1'b1;
                    end else begin
                        state_d = HDR;
                        set_err = 1'b1;
                    end
                end
            end
            STROBE: begin
                // FrameData was loaded on the previous edge, so it is already
                // a full cycle old when the registered strobe rises.
                strobe_en = 1'b1;
                state_d   = HDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            col_q          <= '0;
            frame_q        <= '0;
            FrameData      <= '0;
            cfg_active     <= 1'b0;
            cfg_err        <= 1'b0;
            frames_written <= '0;
        end else begin
            if (ld_hdr) begin
                col_q   <= in_data[HDR_COL_MSB:HDR_COL_LSB];
                frame_q <= in_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
            end
            if (ld_data) begin
                FrameData <= in_data;
            end
            if (set_active) begin
                cfg_active <= 1'b1;
            end else if (clr_active) begin
                cfg_active <= 1'b0;
            end
            if (set_err) begin
                cfg_err <= 1'b1;
            end
            if (strobe_en && (frames_written != 16'hFFFF)) begin
                frames_written <= frames_written + 16'd1;
            end
        end
    end

    frame_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .NumColumns     (NumColumns)
    ) u_strobe_dec (
        .clk   (CLK),
        .resetn(resetn),
        .en    (strobe_en),
        .col   (col_q),
        .frame (frame_q),
        .strobe(FrameStrobe)
    );

endmodule
